// File: rtl/fpu_dmem_sequencer.sv
// FP load/store sequencer: splits lwc1/swc1/ldc1/sdc1 into word accesses on the data memory.
// Define FPU_SEQ_ALIGN_CHECK_EN to reject misaligned addresses and odd double register pairs.
module fpu_dmem_sequencer #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_base,
  input  logic [4:0]        req_ft,
  input  logic [31:0]       req_wdata0,
  input  logic [31:0]       req_wdata1,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       Data2Mem,
  input  logic [31:0]       ReadDataMem,
  output logic              fpr_we,
  output logic [4:0]        fpr_waddr,
  output logic [31:0]       fpr_wdata
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, RD0, RD1, ERR} state_t;

  localparam logic [1:0] OP_LWC1 = 2'b00;
  localparam logic [1:0] OP_SWC1 = 2'b01;
  localparam logic [1:0] OP_LDC1 = 2'b10;
  localparam logic [1:0] OP_SDC1 = 2'b11;

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        ft_q;
  logic [31:0]       wdata1_q;
  logic [ADDR_W-1:0] req_addr;
  logic              req_err;
  logic              unused_bits;

  assign req_addr    = req_base[ADDR_W+1:2];
  assign unused_bits = ^{req_base[31:ADDR_W+2], req_base[1:0]};

`ifdef FPU_SEQ_ALIGN_CHECK_EN
  assign req_err = req_op[1] ? ((req_base[2:0] != 3'b000) || req_ft[0])
                             : (req_base[1:0] != 2'b00);
`else
  assign req_err = 1'b0;
  assign err     = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign stall     = (state == IDLE) ? req_valid : !done;
  assign fpr_wdata = fpr_we ? ReadDataMem : 32'h0;

  // Outputs are registered alongside the state, so each branch sets what the next state drives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_LWC1;
      addr_q    <= '0;
      ft_q      <= '0;
      wdata1_q  <= '0;
      CEN       <= 1'b1;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      A         <= '0;
      Data2Mem  <= '0;
      done      <= 1'b0;
      fpr_we    <= 1'b0;
      fpr_waddr <= '0;
`ifdef FPU_SEQ_ALIGN_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      CEN       <= 1'b1;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      A         <= '0;
      Data2Mem  <= '0;
      done      <= 1'b0;
      fpr_we    <= 1'b0;
      fpr_waddr <= '0;
`ifdef FPU_SEQ_ALIGN_CHECK_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              state <= ERR;
              done  <= 1'b1;
`ifdef FPU_SEQ_ALIGN_CHECK_EN
              err   <= 1'b1;
`endif
            end else begin
              state    <= ACC0;
              op_q     <= req_op;
              addr_q   <= req_addr;
              ft_q     <= req_op[1] ? {req_ft[4:1], 1'b0} : req_ft;
              wdata1_q <= req_wdata1;
              CEN      <= 1'b0;
              A        <= req_addr;
              if (req_op[0]) begin
                WEN      <= 1'b0;
                Data2Mem <= req_wdata0;
              end else begin
                OEN <= 1'b0;
              end
              done <= (req_op == OP_SWC1);
            end
          end
        end
        ACC0: begin
          case (op_q)
            OP_LWC1: begin
              state     <= RD0;
              fpr_we    <= 1'b1;
              fpr_waddr <= ft_q;
              done      <= 1'b1;
            end
            // The word-0 read data returns during ACC1, overlapping the word-1 read.
            OP_LDC1: begin
              state     <= ACC1;
              CEN       <= 1'b0;
              OEN       <= 1'b0;
              A         <= addr_q + 1'b1;
              fpr_we    <= 1'b1;
              fpr_waddr <= ft_q;
            end
            OP_SDC1: begin
              state    <= ACC1;
              CEN      <= 1'b0;
              WEN      <= 1'b0;
              A        <= addr_q + 1'b1;
              Data2Mem <= wdata1_q;
              done     <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
        ACC1: begin
          if (op_q == OP_LDC1) begin
            state     <= RD1;
            fpr_we    <= 1'b1;
            fpr_waddr <= {ft_q[4:1], 1'b1};
            done      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dmem_sequencer.sv
// Self-checking bench for fpu_dmem_sequencer: directed table, mid-op reset, and random ops vs a reference model.
module tb_fpu_dmem_sequencer;

`ifdef FPU_SEQ_ALIGN_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_base;
  logic [4:0]  req_ft;
  logic [31:0] req_wdata0;
  logic [31:0] req_wdata1;
  logic        stall;
  logic        done;
  logic        err;
  logic        CEN;
  logic        WEN;
  logic        OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        fpr_we;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem  [128];
  logic [31:0] ref_mem [128];
  logic [31:0] tb_fpr  [32];
  logic [31:0] rd_q;
  logic        load_en;
  logic [6:0]  load_addr;
  logic [31:0] load_data;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] base;
    logic [4:0]  ft;
    logic [31:0] wd0;
    logic [31:0] wd1;
    int          lat;
    logic [6:0]  a0;
    logic        err;
  } vec_t;

  vec_t        vecs [8];
  int          obs_lat;
  logic [6:0]  obs_a0;
  logic        obs_err;
  int          diff;

  fpu_dmem_sequencer #(.ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_ft(req_ft),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .stall(stall), .done(done), .err(err),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem),
    .fpr_we(fpr_we), .fpr_waddr(fpr_waddr), .fpr_wdata(fpr_wdata)
  );

  always #5 clk = ~clk;

  assign ReadDataMem = rd_q;

  // Single-port memory: read data appears the cycle after the read cycle.
  always @(posedge clk) begin
    if (load_en) tb_mem[load_addr] <= load_data;
    else if (!CEN && !WEN) tb_mem[A] <= Data2Mem;
    rd_q <= (!CEN && !OEN) ? tb_mem[A] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (load_en) tb_fpr[load_addr[4:0]] <= 32'h0;
    else if (fpr_we) tb_fpr[fpr_waddr] <= fpr_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_garbage();
    req_valid  = 1'($urandom_range(0, 1));
    req_op     = 2'($urandom);
    req_base   = $urandom;
    req_ft     = 5'($urandom);
    req_wdata0 = $urandom;
    req_wdata1 = $urandom;
  endtask

  // Starts on a falling edge in IDLE; ends on the falling edge of the idle cycle after done.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] base, input logic [4:0] ft,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                output int o_lat, output logic [6:0] o_a0, output logic o_err);
    bit          is_dbl, is_read, bad, acc, e_we;
    int          nwords, lat, j;
    logic [6:0]  w [2];
    logic [4:0]  pair;
    logic [2:0]  e_ctl;
    logic [6:0]  e_a;
    logic [31:0] e_d2m;

    is_dbl  = op[1];
    is_read = !op[0];
    nwords  = is_dbl ? 2 : 1;
    bad     = CHECK_ON && (is_dbl ? ((base[2:0] != 3'b000) || ft[0]) : (base[1:0] != 2'b00));
    lat     = bad ? 1 : (is_read ? nwords + 1 : nwords);
    w[0]    = base[8:2];
    w[1]    = w[0] + 7'd1;
    pair    = is_dbl ? {ft[4:1], 1'b0} : ft;

    req_valid  = 1'b1;
    req_op     = op;
    req_base   = base;
    req_ft     = ft;
    req_wdata0 = wd0;
    req_wdata1 = wd1;
    #1;
    check_output("t0_ready", 32'(req_ready), 32'd1);
    check_output("t0_stall", 32'(stall), 32'd1);

    o_lat = 0;
    o_a0  = '0;
    o_err = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      acc   = !bad && (k <= nwords);
      j     = (k <= 2) ? k - 1 : 0;
      e_ctl = !acc ? 3'b111 : (is_read ? 3'b010 : 3'b001);
      e_a   = acc ? w[j] : 7'd0;
      e_d2m = (acc && !is_read) ? ((k == 1) ? wd0 : wd1) : 32'h0;
      e_we  = !bad && is_read && (k >= 2);
      check_output("ctl_cen_wen_oen", 32'({CEN, WEN, OEN}), 32'(e_ctl));
      check_output("addr", 32'(A), 32'(e_a));
      check_output("data2mem", Data2Mem, e_d2m);
      check_output("fpr_we", 32'(fpr_we), 32'(e_we));
      if (e_we) begin
        check_output("fpr_waddr", 32'(fpr_waddr), 32'(pair + 5'(k - 2)));
        check_output("fpr_wdata", fpr_wdata, ref_mem[w[k-2]]);
      end
      check_output("done", 32'(done), 32'(k == lat));
      check_output("err", 32'(err), 32'(bad && (k == lat)));
      check_output("stall_busy", 32'(stall), 32'(k < lat));
      check_output("ready_busy", 32'(req_ready), 32'd0);
      if (done && o_lat == 0) o_lat = k;
      if (k == 1) o_a0 = A;
      if (done) o_err = err;
      drive_garbage();
    end

    if (!bad && !is_read) begin
      ref_mem[w[0]] = wd0;
      if (is_dbl) ref_mem[w[1]] = wd1;
    end

    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_output("idle_ready", 32'(req_ready), 32'd1);
    check_output("idle_stall", 32'(stall), 32'd0);
    check_output("idle_done", 32'(done), 32'd0);
    check_output("idle_cen", 32'(CEN), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_output({tag, "_stall"}, 32'(stall), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
    check_output({tag, "_ctl"}, 32'({CEN, WEN, OEN}), 32'h7);
    check_output({tag, "_addr"}, 32'(A), 32'd0);
    check_output({tag, "_d2m"}, Data2Mem, 32'h0);
    check_output({tag, "_fpr_we"}, 32'(fpr_we), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b01, 32'h10,  5'd0, 32'h3F80_0000, 32'h0, 1, 7'd4, 1'b0};
    vecs[1] = '{2'b00, 32'h20,  5'd3, 32'h0, 32'h0, 2, 7'd8, 1'b0};
    vecs[2] = '{2'b10, 32'h1F8, 5'd4, 32'h0, 32'h0, 3, 7'd126, 1'b0};
    vecs[3] = '{2'b11, 32'h1FC, 5'd6, 32'h1111_1111, 32'h2222_2222,
                CHECK_ON ? 1 : 2, CHECK_ON ? 7'd0 : 7'd127, CHECK_ON};
    vecs[4] = '{2'b10, 32'h1FC, 5'd6, 32'h0, 32'h0,
                CHECK_ON ? 1 : 3, CHECK_ON ? 7'd0 : 7'd127, CHECK_ON};
    vecs[5] = '{2'b10, 32'h24,  5'd4, 32'h0, 32'h0,
                CHECK_ON ? 1 : 3, CHECK_ON ? 7'd0 : 7'd9, CHECK_ON};
    vecs[6] = '{2'b10, 32'h20,  5'd5, 32'h0, 32'h0,
                CHECK_ON ? 1 : 3, CHECK_ON ? 7'd0 : 7'd8, CHECK_ON};
    vecs[7] = '{2'b00, 32'h22,  5'd1, 32'h0, 32'h0,
                CHECK_ON ? 1 : 2, CHECK_ON ? 7'd0 : 7'd8, CHECK_ON};

    for (int i = 0; i < 128; i++) ref_mem[i] = $urandom;
    ref_mem[8]   = 32'h4049_0FDB;
    ref_mem[127] = ref_mem[127] | 32'h1;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_base   = '0;
    req_ft     = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;
    load_en    = 1'b1;
    load_addr  = '0;
    load_data  = '0;

    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      load_addr = 7'(i);
      load_data = ref_mem[i];
      @(negedge clk);
    end
    load_en = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset in the middle of ldc1");
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_base  = 32'h1F8;
    req_ft    = 5'd4;
    #1;
    check_output("rst_t0_stall", 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("rst_t1_addr", 32'(A), 32'd126);
    check_output("rst_t1_ctl", 32'({CEN, WEN, OEN}), 32'b010);
    @(negedge clk);
    check_output("rst_t2_addr", 32'(A), 32'd127);
    check_output("rst_t2_fpr_we", 32'(fpr_we), 32'd1);
    check_output("rst_t2_waddr", 32'(fpr_waddr), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop");
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_after_fpr_we", 32'(fpr_we), 32'd0);
    check_output("rst_fpr5_untouched", tb_fpr[5], 32'h0);
    check_output("rst_fpr4_written", tb_fpr[4], ref_mem[126]);

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].base, vecs[i].ft, vecs[i].wd0, vecs[i].wd1,
                     obs_lat, obs_a0, obs_err);
      check_output($sformatf("vec%0d_latency", i), 32'(obs_lat), 32'(vecs[i].lat));
      check_output($sformatf("vec%0d_first_addr", i), 32'(obs_a0), 32'(vecs[i].a0));
      check_output($sformatf("vec%0d_err", i), 32'(obs_err), 32'(vecs[i].err));
    end
    check_output("lwc1_fpr3", tb_fpr[3], 32'h4049_0FDB);

    $display("[TB] random operations");
    for (int n = 0; n < 80; n++) begin
      logic [31:0] rb;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rb = $urandom;
      if ($urandom_range(0, 3) != 0) rb[2:0] = 3'b000;
      apply_stimulus(2'($urandom), rb, 5'($urandom), $urandom, $urandom,
                     obs_lat, obs_a0, obs_err);
    end

    diff = 0;
    for (int i = 0; i < 128; i++) if (tb_mem[i] !== ref_mem[i]) diff++;
    check_output("memory_image_diffs", 32'(diff), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
